id_inst_buffer: RTL and testbench



---
 rtl/id_inst_buffer_pkg.sv | 15 +
 rtl/id_inst_buffer_ibuf_ram.sv | 23 ++
 rtl/id_inst_buffer.sv | 112 +++++++++++
 tb/tb_id_inst_buffer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/id_inst_buffer_pkg.sv
// Shared widths and head-source encoding for the IF->ID instruction buffer.
// An entry is packed {pc, inst} with pc in the high bits.
package id_inst_buffer_pkg;

  localparam int IBUF_PC_W     = 32;
  localparam int IBUF_INST_W   = 32;
  localparam int IBUF_ENTRY_WD = IBUF_PC_W + IBUF_INST_W;

  typedef enum logic [1:0] {
    HEAD_NONE   = 2'd0,
    HEAD_QUEUE  = 2'd1,
    HEAD_BYPASS = 2'd2
  } head_src_e;

endpackage

// File: rtl/id_inst_buffer_ibuf_ram.sv
// Entry storage for the instruction buffer: one synchronous write port,
// one asynchronous read port, data deliberately left without reset.
module ibuf_ram #(
  parameter int DEPTH = 4,
  parameter int WD    = 64
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WD-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WD-1:0]            o_rdata
);

  logic [WD-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/id_inst_buffer.sv
// Instruction buffer between IF and ID: captures SRAM responses, bypasses the
// in-flight response when empty, and drops everything buffered on a redirect.
module id_inst_buffer
  import id_inst_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = IBUF_PC_W,
  parameter int INST_W = IBUF_INST_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       req_valid,
  input  logic [PC_W-1:0]            req_pc,
  output logic                       req_ready,
  input  logic [INST_W-1:0]          inst_sram_rdata,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc,
  output logic [INST_W-1:0]          out_inst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(DEPTH+1);
  localparam int ENTRY_WD = PC_W + INST_W;

  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_inflight;
  logic [PC_W-1:0]     r_inflight_pc;

  head_src_e           w_head_src;
  logic [ENTRY_WD-1:0] w_ram_rdata;
  logic [CNT_W:0]      w_occ;
  logic                w_deq;
  logic                w_q_deq;
  logic                w_byp_deq;
  logic                w_capture;
  logic                w_accept;

  always_comb begin
    w_head_src = HEAD_NONE;
    if (r_count != '0)   w_head_src = HEAD_QUEUE;
    else if (r_inflight) w_head_src = HEAD_BYPASS;
  end

  always_comb begin
    out_pc   = '0;
    out_inst = '0;
    case (w_head_src)
      HEAD_QUEUE: begin
        out_pc   = w_ram_rdata[ENTRY_WD-1 -: PC_W];
        out_inst = w_ram_rdata[INST_W-1:0];
      end
      HEAD_BYPASS: begin
        out_pc   = r_inflight_pc;
        out_inst = inst_sram_rdata;
      end
      default: ;
    endcase
  end

  assign out_valid = (w_head_src != HEAD_NONE);
  assign count     = r_count;

  // Occupancy counts the in-flight response so a slot is reserved for it.
  assign w_occ     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign req_ready = flush | (w_occ < (CNT_W+1)'(DEPTH));
  assign w_accept  = req_valid & req_ready;

  assign w_deq     = out_valid & out_ready;
  assign w_q_deq   = w_deq & (w_head_src == HEAD_QUEUE);
  assign w_byp_deq = w_deq & (w_head_src == HEAD_BYPASS);
  assign w_capture = r_inflight & ~w_byp_deq;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) r_inflight_pc <= req_pc;
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_q_deq)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_capture) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_capture) - CNT_W'(w_q_deq);
      end
    end
  end

  ibuf_ram #(
    .DEPTH (DEPTH),
    .WD    (ENTRY_WD)
  ) u_ibuf_ram (
    .clk     (clk),
    .i_we    (w_capture & ~flush),
    .i_waddr (r_wr_ptr),
    .i_wdata ({r_inflight_pc, inst_sram_rdata}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_id_inst_buffer.sv
// Self-checking bench for id_inst_buffer: directed scenarios plus random
// traffic, checked against a queue-level model of the buffer.
module tb_id_inst_buffer;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  logic                       clk = 1'b0;
  logic                       resetn;
  logic                       req_valid;
  logic [PC_W-1:0]            req_pc;
  logic                       req_ready;
  logic [INST_W-1:0]          inst_sram_rdata;
  logic                       flush;
  logic                       out_valid;
  logic [PC_W-1:0]            out_pc;
  logic [INST_W-1:0]          out_inst;
  logic                       out_ready;
  logic [$clog2(DEPTH+1)-1:0] count;

  always #5 clk = ~clk;

  id_inst_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_pc          (req_pc),
    .req_ready       (req_ready),
    .inst_sram_rdata (inst_sram_rdata),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_ready       (out_ready),
    .count           (count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: ordered list of buffered {pc, inst}, plus the one outstanding fetch.
  logic [63:0] mq[$];
  logic        m_infl;
  logic [31:0] m_pc;
  logic        t_acc;
  int          n_deq;
  logic [31:0] last_deq_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    if (pc == 32'hBFC0_0000) return 32'h3C08_BFAF;
    return {pc[15:0], ~pc[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_infl = 1'b0;
    m_pc   = '0;
  endtask

  // Called at a falling edge; drives one cycle, checks outputs, advances model.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic ordy, input logic fl);
    logic        exp_valid, exp_ready, from_q, deq;
    logic [63:0] head;
    req_valid       = rv;
    req_pc          = rpc;
    out_ready       = ordy;
    flush           = fl;
    inst_sram_rdata = m_infl ? inst_of(m_pc) : $urandom;
    #1;
    from_q    = (mq.size() > 0);
    exp_valid = from_q || m_infl;
    exp_ready = fl || ((mq.size() + int'(m_infl)) < DEPTH);
    head      = from_q ? mq[0] : {m_pc, inst_of(m_pc)};
    check("out_valid", out_valid, exp_valid);
    check("count", count, mq.size());
    check("req_ready", req_ready, exp_ready);
    if (exp_valid) begin
      check("out_pc", out_pc, head[63:32]);
      check("out_inst", out_inst, head[31:0]);
    end
    deq   = exp_valid && ordy;
    t_acc = rv && exp_ready;
    if (!fl && m_infl && !(deq && !from_q)) check("capture_below_depth", count < DEPTH, 1);
    @(posedge clk);
    if (deq) begin
      n_deq++;
      last_deq_pc = head[63:32];
    end
    if (fl) begin
      mq.delete();
    end else begin
      if (deq && from_q) void'(mq.pop_front());
      if (m_infl && !(deq && !from_q)) mq.push_back({m_pc, inst_of(m_pc)});
    end
    m_infl = t_acc;
    if (t_acc) m_pc = rpc;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (mq.size() == 0 && !m_infl) break;
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end
    check("drain_empty", out_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] next_pc;
    int          accepted;
    logic        rv, fl;

    resetn = 1'b0; req_valid = 1'b0; req_pc = '0; out_ready = 1'b0;
    flush = 1'b0; inst_sram_rdata = '0;
    model_reset();
    n_deq = 0; last_deq_pc = '0;
    #12;
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    check("rst_req_ready", req_ready, 1'b1);
    @(negedge clk);
    resetn = 1'b1;

    // Bypass: head visible the cycle after the fetch, queue stays empty.
    step(1'b1, 32'hBFC0_0000, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    drain();

    // Fill to DEPTH with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
    step(1'b1, 32'h10, 1'b0, 1'b0);
    check("fill_count_full", count, DEPTH);
    check("fill_req_ready_low", req_ready, 1'b0);
    drain();

    // Flush with three queued and one in flight; redirect target kept.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h80 + 32'(i * 4), 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b1);
    check("flush_count", count, 0);
    check("flush_head_pc", out_pc, 32'h40);
    drain();

    // Steady state with count=2: capture and dequeue together.
    step(1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0);
    step(1'b1, 32'h108, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h10C + 32'(i * 4), 1'b1, 1'b0);
    check("steady_count", count, 2);
    drain();

    // Twenty sequential PCs under random back-pressure.
    n_deq = 0; accepted = 0; next_pc = 32'h2000;
    for (int i = 0; i < 300; i++) begin
      if (accepted == 20 && mq.size() == 0 && !m_infl) break;
      step(accepted < 20, next_pc, 1'($urandom_range(0, 1)), 1'b0);
      if (t_acc) begin
        accepted++;
        next_pc = next_pc + 32'd4;
      end
    end
    check("seq20_dequeued", n_deq, 20);
    check("seq20_last_pc", last_deq_pc, 32'h2000 + 32'd76);

    // Random traffic including redirects.
    next_pc = 32'h4000;
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 11) == 0);
      pc = fl ? {20'h0, $urandom_range(0, 1023), 2'b00} : next_pc;
      step(rv, pc, ($urandom_range(0, 2) != 0), fl);
      if (t_acc) next_pc = pc + 32'd4;
    end
    drain();

    // Asynchronous reset mid-operation with count=3.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
    check("pre_areset_count", count, 3);
    req_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 1'b0);
    check("areset_req_ready", req_ready, 1'b1);
    check("areset_count", count, 0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
